// File: rtl/conv_pkg.sv
// Shared convolutional-code constants and parity helper for the encoder and the
// Viterbi decoder blocks (bmc/acs/traceback).
package conv_pkg;

    localparam int unsigned CONV_K = 3;
    localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

    typedef enum logic {ST_RUN, ST_FLUSH} conv_enc_state_t;

    // r = {b, s}: bit K-1 taps the current input, s[K-2] is the most recent prior bit
    function automatic logic [1:0] conv_pair(
        input logic              b,
        input logic [CONV_K-2:0] s,
        input logic [CONV_K-1:0] g0 = CONV_G0,
        input logic [CONV_K-1:0] g1 = CONV_G1
    );
        logic [CONV_K-1:0] r;
        r = {b, s};
        return {^(g1 & r), ^(g0 & r)};
    endfunction

endpackage

// File: rtl/conv_encoder_if.sv
// Bit-in / code-pair-out handshake bundle for conv_encoder.
interface conv_encoder_if;

    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_pair;
    logic       out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_pair, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_pair, out_last
    );

endinterface

// File: rtl/conv_encoder.sv
// Rate-1/2 convolutional encoder with optional zero-tail termination so the
// decoder trellis ends in state 0.
module conv_encoder
    import conv_pkg::*;
#(
    parameter int unsigned    K       = CONV_K,
    parameter logic [K-1:0]   G0      = CONV_G0,
    parameter logic [K-1:0]   G1      = CONV_G1,
    parameter bit             TAIL_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    conv_encoder_if.slave bus
);

    localparam int unsigned TW = $clog2(K);

    conv_enc_state_t state;
    logic [K-2:0]    s;
    logic [TW-1:0]   tail_cnt;
    logic            load_ok;
    logic [1:0]      data_pair;
    logic [1:0]      tail_pair;
    logic [K-2:0]    data_next;
    logic [K-2:0]    tail_next;

    assign load_ok      = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !rst && (state == ST_RUN) && load_ok;

    assign data_pair = conv_pair(bus.in_bit, s, G0, G1);
    assign tail_pair = conv_pair(1'b0, s, G0, G1);
    assign data_next = {bus.in_bit, s[K-2:1]};
    assign tail_next = {1'b0, s[K-2:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            s             <= '0;
            tail_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_pair  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.out_valid <= 1'b1;
                        bus.out_pair  <= data_pair;
                        if (bus.in_last && TAIL_EN) begin
                            s            <= data_next;
                            tail_cnt     <= TW'(K - 1);
                            bus.out_last <= 1'b0;
                            state        <= ST_FLUSH;
                        end else if (bus.in_last) begin
                            s            <= '0;
                            bus.out_last <= 1'b1;
                        end else begin
                            s            <= data_next;
                            bus.out_last <= 1'b0;
                        end
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // load_ok covers both the idle and the zero-bubble handshake case
                    if (load_ok) begin
                        bus.out_valid <= 1'b1;
                        bus.out_pair  <= tail_pair;
                        tail_cnt      <= tail_cnt - TW'(1);
                        if (tail_cnt == TW'(1)) begin
                            s            <= '0;
                            bus.out_last <= 1'b1;
                            state        <= ST_RUN;
                        end else begin
                            s            <= tail_next;
                            bus.out_last <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: directed frames plus randomized frames
// and backpressure against a bit-history reference model.
module tb_conv_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid  = 1'b0;
    logic       in_bit    = 1'b0;
    logic       in_last   = 1'b0;
    logic       out_ready = 1'b0;
    logic       use_notail = 1'b0;

    conv_encoder_if bus1 ();
    conv_encoder_if bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_bit    = in_bit;
    assign bus1.in_last   = in_last;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_bit    = in_bit;
    assign bus0.in_last   = in_last;
    assign bus0.out_ready = out_ready;

    conv_encoder #(.TAIL_EN(1'b1)) dut_tail (.clk(clk), .rst(rst), .bus(bus1));
    conv_encoder #(.TAIL_EN(1'b0)) dut_notail (.clk(clk), .rst(rst), .bus(bus0));

    logic       ob_valid, ob_in_ready, ob_last;
    logic [1:0] ob_pair;
    assign ob_valid    = use_notail ? bus0.out_valid : bus1.out_valid;
    assign ob_in_ready = use_notail ? bus0.in_ready  : bus1.in_ready;
    assign ob_last     = use_notail ? bus0.out_last  : bus1.out_last;
    assign ob_pair     = use_notail ? bus0.out_pair  : bus1.out_pair;

    int n_checks = 0;
    int n_fail   = 0;

    bit         q_bit[$];
    bit         q_last[$];
    logic [1:0] got_pair[$];
    bit         got_last[$];
    logic [1:0] exp_pair[$];
    bit         exp_last[$];
    int         stall_err;
    int         first_out;
    int         last_out;
    bit         drv_timeout;

    // Reference: out[0] = parity(111 & r), out[1] = parity(101 & r), r = b*4 + h1*2 + h2
    function automatic logic [1:0] ref_enc(input int b, input int h1, input int h2);
        int r;
        r = b * 4 + h1 * 2 + h2;
        return {1'($countones(r & 5) % 2), 1'($countones(r & 7) % 2)};
    endfunction

    task automatic build_model(input bit tail_en);
        int h1 = 0;
        int h2 = 0;
        exp_pair.delete();
        exp_last.delete();
        for (int i = 0; i < q_bit.size(); i++) begin
            exp_pair.push_back(ref_enc(int'(q_bit[i]), h1, h2));
            h2 = h1;
            h1 = int'(q_bit[i]);
            if (q_last[i]) begin
                if (tail_en) begin
                    exp_last.push_back(1'b0);
                    for (int t = 0; t < 2; t++) begin
                        exp_pair.push_back(ref_enc(0, h1, h2));
                        exp_last.push_back(t == 1);
                        h2 = h1;
                        h1 = 0;
                    end
                end else begin
                    exp_last.push_back(1'b1);
                end
                h1 = 0;
                h2 = 0;
            end else begin
                exp_last.push_back(1'b0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random; valid_mode: 0 = always, 1 = random
    task automatic drive(input int n_pairs, input int ready_mode, input int valid_mode);
        int         idx = 0;
        int         c = 0;
        bit         stalled = 1'b0;
        logic [1:0] pp = '0;
        bit         pl = 1'b0;
        got_pair.delete();
        got_last.delete();
        stall_err = 0;
        first_out = -1;
        last_out = -1;
        drv_timeout = 1'b0;
        while (got_pair.size() < n_pairs && c < 2000) begin
            @(negedge clk);
            case (ready_mode)
                0: out_ready = 1'b1;
                1: out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid = (idx < q_bit.size()) && (valid_mode == 0 || $urandom_range(0, 3) != 0);
            in_bit   = (idx < q_bit.size()) ? q_bit[idx] : 1'b0;
            in_last  = (idx < q_bit.size()) ? q_last[idx] : 1'b0;
            #1;
            if (stalled && (!ob_valid || ob_pair !== pp || ob_last !== pl)) stall_err++;
            if (ob_valid && !out_ready && ob_in_ready) stall_err++;
            stalled = ob_valid && !out_ready;
            pp = ob_pair;
            pl = ob_last;
            if (ob_valid && out_ready) begin
                got_pair.push_back(ob_pair);
                got_last.push_back(ob_last);
                if (first_out < 0) first_out = c;
                last_out = c;
            end
            if (in_valid && ob_in_ready) idx++;
            c++;
        end
        if (c >= 2000) drv_timeout = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        use_notail = 1'b0;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (ob_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_during: got %b expected 0", ob_in_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (ob_valid !== 1'b0 || ob_pair !== 2'b00 || ob_last !== 1'b0 || ob_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got valid=%b pair=%b last=%b in_ready=%b expected 0 00 0 0",
                     ob_valid, ob_pair, ob_last, ob_in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (ob_in_ready !== 1'b1 || ob_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got in_ready=%b valid=%b expected 1 0", ob_in_ready, ob_valid);
        end
    endtask

    task automatic test_frame_1011(input int ready_mode, input string tag);
        logic [1:0] ref_p[6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
        use_notail = 1'b0;
        do_reset();
        q_bit = '{1, 0, 1, 1};
        q_last = '{0, 0, 0, 1};
        drive(6, ready_mode, 0);
        n_checks++;
        if (got_pair.size() != 6) begin
            n_fail++; $display("FAIL %s_count: got %0d pairs expected 6", tag, got_pair.size());
        end
        for (int i = 0; i < 6 && i < got_pair.size(); i++) begin
            n_checks++;
            if (got_pair[i] !== ref_p[i] || got_last[i] !== (i == 5)) begin
                n_fail++;
                $display("FAIL %s_pair[%0d]: got %b last=%b expected %b last=%b",
                         tag, i, got_pair[i], got_last[i], ref_p[i], (i == 5));
            end
        end
        n_checks++;
        if (stall_err != 0) begin
            n_fail++; $display("FAIL %s_stall: got %0d stall violations expected 0", tag, stall_err);
        end
    endtask

    task automatic test_single_bit();
        logic [1:0] ref_p[3] = '{2'b11, 2'b01, 2'b11};
        use_notail = 1'b0;
        do_reset();
        got_pair.delete();
        got_last.delete();
        @(negedge clk);
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (ob_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_accept: got in_ready=%b expected 1", ob_in_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            in_bit = 1'b0;
            in_last = 1'b1;
            #1;
            n_checks++;
            if (ob_in_ready !== (k == 3)) begin
                n_fail++; $display("FAIL single_in_ready[%0d]: got %b expected %b", k, ob_in_ready, (k == 3));
            end
            if (ob_valid && out_ready) begin
                got_pair.push_back(ob_pair);
                got_last.push_back(ob_last);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (got_pair.size() != 3) begin
            n_fail++; $display("FAIL single_count: got %0d expected 3", got_pair.size());
        end
        for (int i = 0; i < 3 && i < got_pair.size(); i++) begin
            n_checks++;
            if (got_pair[i] !== ref_p[i] || got_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL single_pair[%0d]: got %b last=%b expected %b last=%b",
                         i, got_pair[i], got_last[i], ref_p[i], (i == 2));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ref_p[8] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11};
        use_notail = 1'b0;
        do_reset();
        q_bit = '{1, 1, 0, 1};
        q_last = '{0, 1, 0, 1};
        drive(8, 0, 0);
        n_checks++;
        if (got_pair.size() != 8) begin
            n_fail++; $display("FAIL b2b_count: got %0d expected 8", got_pair.size());
        end
        for (int i = 0; i < 8 && i < got_pair.size(); i++) begin
            n_checks++;
            if (got_pair[i] !== ref_p[i] || got_last[i] !== (i == 3 || i == 7)) begin
                n_fail++;
                $display("FAIL b2b_pair[%0d]: got %b last=%b expected %b last=%b",
                         i, got_pair[i], got_last[i], ref_p[i], (i == 3 || i == 7));
            end
        end
        n_checks++;
        if (last_out - first_out + 1 != 8) begin
            n_fail++; $display("FAIL b2b_no_bubble: got span %0d cycles expected 8", last_out - first_out + 1);
        end
    endtask

    task automatic test_reset_mid_flush();
        int seen = 0;
        logic [1:0] ref_p[3] = '{2'b11, 2'b01, 2'b11};
        use_notail = 1'b0;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_bit = 1'b1; in_last = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (ob_valid !== 1'b0 || ob_last !== 1'b0) begin
            n_fail++; $display("FAIL flush_reset_out: got valid=%b last=%b expected 0 0", ob_valid, ob_last);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (ob_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL flush_reset_no_tail: got %0d valid cycles expected 0", seen);
        end
        q_bit = '{1};
        q_last = '{1};
        drive(3, 0, 0);
        n_checks++;
        if (got_pair.size() != 3) begin
            n_fail++; $display("FAIL flush_reset_count: got %0d expected 3", got_pair.size());
        end
        for (int i = 0; i < 3 && i < got_pair.size(); i++) begin
            n_checks++;
            if (got_pair[i] !== ref_p[i] || got_last[i] !== (i == 2)) begin
                n_fail++;
                $display("FAIL flush_reset_pair[%0d]: got %b last=%b expected %b last=%b",
                         i, got_pair[i], got_last[i], ref_p[i], (i == 2));
            end
        end
    endtask

    task automatic test_no_tail();
        logic [1:0] ref_p[3] = '{2'b11, 2'b10, 2'b11};
        bit         ref_l[3] = '{0, 1, 1};
        use_notail = 1'b1;
        do_reset();
        q_bit = '{1, 1, 1};
        q_last = '{0, 1, 1};
        drive(3, 0, 0);
        n_checks++;
        if (got_pair.size() != 3) begin
            n_fail++; $display("FAIL notail_count: got %0d expected 3", got_pair.size());
        end
        for (int i = 0; i < 3 && i < got_pair.size(); i++) begin
            n_checks++;
            if (got_pair[i] !== ref_p[i] || got_last[i] !== ref_l[i]) begin
                n_fail++;
                $display("FAIL notail_pair[%0d]: got %b last=%b expected %b last=%b",
                         i, got_pair[i], got_last[i], ref_p[i], ref_l[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int round = 0; round < 6; round++) begin
            use_notail = 1'(round % 2);
            do_reset();
            q_bit.delete();
            q_last.delete();
            for (int f = 0; f < 4; f++) begin
                int len = int'($urandom_range(1, 8));
                for (int j = 0; j < len; j++) begin
                    q_bit.push_back(1'($urandom_range(0, 1)));
                    q_last.push_back(j == len - 1);
                end
            end
            build_model(!use_notail);
            drive(exp_pair.size(), 2, 1);
            n_checks++;
            if (got_pair.size() != exp_pair.size() || drv_timeout) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d pairs timeout=%b expected %0d",
                         round, got_pair.size(), drv_timeout, exp_pair.size());
            end
            for (int i = 0; i < exp_pair.size() && i < got_pair.size(); i++) begin
                n_checks++;
                if (got_pair[i] !== exp_pair[i] || got_last[i] !== exp_last[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_pair[%0d]: got %b last=%b expected %b last=%b",
                             round, i, got_pair[i], got_last[i], exp_pair[i], exp_last[i]);
                end
            end
            n_checks++;
            if (stall_err != 0) begin
                n_fail++; $display("FAIL rand%0d_stall: got %0d violations expected 0", round, stall_err);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_1011(0, "frame1011");
        test_single_bit();
        test_frame_1011(1, "backpressure");
        test_back_to_back();
        test_reset_mid_flush();
        test_no_tail();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
